md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Consumes the decode stage's start pulse, operation class and forwarded Rs/Rt operands.
- Computes mult/multu/div/divu over a fixed multi-cycle latency into HI/LO; services mthi/mtlo writes.
- Exposes busy so decode-stage hazard logic stalls any mult-type instruction (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) while busy or start is high.

Parameters:
MULT_CYCLES, 5, cycles busy stays high after a mult/multu start (>=1)
DIV_CYCLES, 10, cycles busy stays high after a div/divu start (>=1)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  pulse; launch op_sel (mult/multu/div/divu) this edge
op_sel  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 see Optional Feature
wr_en  input  1  perform mthi/mtlo (op_sel 4/5) this edge
src_a  input  32  Rs operand (forwarded)
src_b  input  32  Rt operand (forwarded)
busy  output  1  registered; high while a launched operation is in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: busy=0, hi=0, lo=0, internal counter=0, latched operands/op=0. Reset mid-operation aborts it; no HI/LO update follows.
- Launch: at posedge with start=1 and busy=0 and op_sel in 0..3, latch src_a, src_b, op_sel; counter <= MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); busy <= 1.
- In flight: each posedge with counter>1 decrements counter.
- Retire: at posedge with counter==1: {hi,lo} <= result, counter <= 0, busy <= 0. Busy is therefore high for exactly N cycles after the launch edge. HI/LO are readable (mfhi/mflo) on the cycle after busy falls.
- Result rules:
  - mult: signed 32x32 -> 64 bit; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64 bit; same split.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend. 0x80000000 / -1 gives lo=0x80000000, hi=0.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (div/divu with latched src_b=0): full DIV_CYCLES busy, hi/lo unchanged at retire.
- Results are computed from the latched operands only. Changes on src_a/src_b after launch have no effect.
- mthi/mtlo: at posedge with wr_en=1 and busy=0: op 4 sets hi <= src_a, op 5 sets lo <= src_a. No busy, single cycle.
- While busy=1:
  - start and wr_en are ignored; no relaunch and no HI/LO write. Decode-stage stall logic must prevent this case.
  - hi/lo hold their pre-launch values until retire.
- Simultaneous start and wr_en with busy=0: start wins; wr_en is ignored.
- start with op_sel 4..7 (feature off) is ignored.
- A launch edge coincident with the retire edge cannot occur because busy=1 at that edge. Back-to-back: a new start on the first cycle with busy=0 launches normally.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op_sel 6 = madd: {hi,lo} <= {hi,lo} + signed(src_a*src_b).
  - op_sel 7 = maddu: unsigned product, same accumulate.
  - Both launch with MULT_CYCLES latency. The accumulate uses the {hi,lo} value present at the retire edge, taken modulo 2^64.
- Not defined: op_sel 6/7 ignored on start; no accumulator adder synthesized.

Test Plan:
- reset, then start op=0 with src_a=0xFFFFFFFE (-2), src_b=3 -> busy high exactly 5 cycles; after retire hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- start op=1 with 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- start op=2 with -7, 2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. op=3 with 7, 0 after mthi 0x11/mtlo 0x22 -> hi=0x11, lo=0x22 unchanged after 10 busy cycles.
- During busy of a div: drive wr_en op=4 src_a=0xDEAD and start op=0 -> both ignored; retire yields div result; busy falls on cycle 10.
- Assert reset at cycle 3 of a mult -> busy=0, hi=lo=0 on the next cycle; no later update.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu 1x1 -> hi=1, lo=0 after 5 cycles. Without the macro: same stimulus -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/md_unit.sv
// EX-stage MIPS multiply/divide unit: fixed-latency mult/multu/div/divu into HI/LO plus mthi/mtlo writes.
// Optional madd/maddu accumulate (op_sel 6/7) is built only when MDU_MADD_EN is defined.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op_sel,
  input  logic        wr_en,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic          op_ok;
  logic          is_div;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   q_s;
  logic [31:0]   r_s;
  logic [63:0]   result;

  always_comb begin
`ifdef MDU_MADD_EN
    op_ok = (op_sel != OP_MTHI) && (op_sel != OP_MTLO);
`else
    op_ok = !op_sel[2];
`endif
    is_div = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
  end

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  assign a_mag = a_q[31] ? (32'd0 - a_q) : a_q;
  assign b_mag = b_q[31] ? (32'd0 - b_q) : b_q;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a_q[31] ? (32'd0 - r_mag) : r_mag;

  // Divide by zero leaves HI/LO as they are.
  always_comb begin
    result = {hi, lo};
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   if (b_q != 32'd0) result = {r_s, q_s};
      OP_DIVU:  if (b_q != 32'd0) result = {a_q % b_q, a_q / b_q};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MADDU: result = {hi, lo} + prod_u;
`endif
      default:  result = {hi, lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (busy) begin
      if (cnt == CW'(1)) begin
        busy     <= 1'b0;
        cnt      <= '0;
        {hi, lo} <= result;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (start) begin
      if (op_ok) begin
        busy <= 1'b1;
        op_q <= op_sel;
        a_q  <= src_a;
        b_q  <= src_b;
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
    end else if (wr_en) begin
      if (op_sel == OP_MTHI) hi <= src_a;
      if (op_sel == OP_MTLO) lo <= src_a;
    end
  end

endmodule
